// File: rtl/fetch_sequencer.sv
// fetch_sequencer: PC, IR and stage register with req/ack instruction fetch and timeout halt
module fetch_sequencer #(
    parameter int ADDR_W   = 32,
    parameter int INSTR_W  = 32,
    parameter int MAX_WAIT = 15
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [2:0]         next_state,
    input  logic [1:0]         PC_src,
    input  logic [ADDR_W-1:0]  jump_target,
    input  logic [15:0]        br_offset,
    input  logic [ADDR_W-1:0]  ret_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_data,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    output logic [2:0]         state,
    output logic [INSTR_W-1:0] ir,
    output logic [5:0]         opcode,
    output logic [1:0]         mode,
    output logic [ADDR_W-1:0]  pc,
    output logic [15:0]        instr_count,
    output logic               fetch_err
);
    localparam int CW = $clog2(MAX_WAIT + 1);
    localparam logic [2:0] S_IF = 3'd0, S_ID = 3'd1, S_WB = 3'd4;
    typedef enum logic [1:0] {F_IDLE, F_WAIT, F_HALT} fetch_t;
    fetch_t fstate;
    logic [CW-1:0] wait_cnt;
    logic [2:0] eff_next;
    logic [ADDR_W-1:0] pc_next;
    always_comb eff_next = next_state > S_WB ? S_IF : next_state;
    always_comb pc_next = PC_src == 2'b00 ? pc + ADDR_W'(1) :
                          PC_src == 2'b01 ? jump_target :
                          PC_src == 2'b10 ? pc + {{(ADDR_W-16){br_offset[15]}}, br_offset} : ret_addr;
    assign imem_addr = pc;
    assign opcode = ir[31:26];
    assign mode = ir[1:0];
    always_ff @(posedge clk) begin
        if (reset) begin
            pc <= '0;
            ir <= '0;
            state <= S_IF;
            imem_req <= 1'b0;
            fstate <= F_IDLE;
            wait_cnt <= '0;
            instr_count <= '0;
            fetch_err <= 1'b0;
        end else begin
            case (fstate)
                F_IDLE: if (state == S_IF && !fetch_err) begin
                    imem_req <= 1'b1;
                    fstate <= F_WAIT;
                end
                F_WAIT: if (imem_ack) begin
                    ir <= imem_data;
                    imem_req <= 1'b0;
                    state <= S_ID;
                    instr_count <= instr_count + 16'd1;
                    wait_cnt <= '0;
                    fstate <= F_IDLE;
                end else begin
                    wait_cnt <= wait_cnt + CW'(1);
                    if (wait_cnt == CW'(MAX_WAIT - 1)) begin
                        imem_req <= 1'b0;
                        fetch_err <= 1'b1;
                        fstate <= F_HALT;
                    end
                end
                default: ;
            endcase
            // an illegal stage recovers to IF without touching the PC
            if (state != S_IF) begin
                state <= state > S_WB ? S_IF : eff_next;
                if (state <= S_WB && eff_next == S_IF) pc <= pc_next;
            end
        end
    end
endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: scenario tasks plus randomized walks against a transaction-level model
module tb_fetch_sequencer;
    logic clk = 0, reset = 1;
    logic [2:0] next_state = 0;
    logic [1:0] PC_src = 0;
    logic [31:0] jump_target = 0, ret_addr = 0, imem_data = 0;
    logic [15:0] br_offset = 0;
    logic imem_ack = 0;
    logic imem_req, fetch_err;
    logic [31:0] imem_addr, ir, pc;
    logic [2:0] state;
    logic [5:0] opcode;
    logic [1:0] mode;
    logic [15:0] instr_count;
    int checks = 0, failures = 0;
    logic [31:0] exp_pc = 0, exp_ir = 0;
    logic [15:0] exp_cnt = 0;

    fetch_sequencer dut (.clk(clk), .reset(reset), .next_state(next_state), .PC_src(PC_src),
        .jump_target(jump_target), .br_offset(br_offset), .ret_addr(ret_addr), .imem_ack(imem_ack),
        .imem_data(imem_data), .imem_req(imem_req), .imem_addr(imem_addr), .state(state), .ir(ir),
        .opcode(opcode), .mode(mode), .pc(pc), .instr_count(instr_count), .fetch_err(fetch_err));

    always #5 clk = ~clk;

    function automatic logic [31:0] ref_pc(logic [31:0] p, logic [1:0] s, logic [31:0] jt, logic [15:0] bo, logic [31:0] ra);
        case (s)
            2'd0: return p + 1;
            2'd1: return jt;
            2'd2: return p + int'($signed(bo));
            default: return ra;
        endcase
    endfunction

    task tick();
        @(posedge clk);
        #1;
    endtask

    // ack is raised during the (lat+1)-th cycle that imem_req is high
    task fetch(input logic [31:0] data, input int lat);
        int t, n;
        t = 0;
        n = 0;
        while (!imem_req && t < 20) begin tick(); t++; end
        while (imem_req && n < 40) begin
            n++;
            if (n == lat + 1) begin imem_ack = 1; imem_data = data; end
            checks++;
            if (imem_addr !== exp_pc) begin failures++; $display("FAIL fetch_addr got=%h exp=%h", imem_addr, exp_pc); end
            tick();
            imem_ack = 0;
        end
        exp_ir = data;
        exp_cnt++;
        checks++;
        if (n !== lat + 1) begin failures++; $display("FAIL req_cycles got=%0d exp=%0d", n, lat + 1); end
        checks++;
        if (state !== 3'd1 || ir !== exp_ir || instr_count !== exp_cnt)
            begin failures++; $display("FAIL fetch_result state=%0d ir=%h cnt=%0d exp ir=%h cnt=%0d", state, ir, instr_count, exp_ir, exp_cnt); end
    endtask

    task go(input logic [2:0] ns, input logic [1:0] src);
        logic [2:0] eff;
        eff = ns > 3'd4 ? 3'd0 : ns;
        next_state = ns;
        PC_src = src;
        if (eff == 3'd0) exp_pc = ref_pc(exp_pc, src, jump_target, br_offset, ret_addr);
        tick();
        checks++;
        if (state !== eff || pc !== exp_pc) begin failures++; $display("FAIL stage_step state=%0d pc=%h exp state=%0d pc=%h", state, pc, eff, exp_pc); end
    endtask

    task test_reset();
        reset = 1;
        tick();
        tick();
        checks++;
        if (pc !== 0 || ir !== 0 || state !== 0 || imem_req !== 0 || instr_count !== 0 || fetch_err !== 0)
            begin failures++; $display("FAIL reset_state pc=%h ir=%h st=%0d req=%b cnt=%0d err=%b", pc, ir, state, imem_req, instr_count, fetch_err); end
        exp_pc = 0; exp_ir = 0; exp_cnt = 0;
        reset = 0;
    endtask

    task test_fetch_latency();
        fetch(32'h3000_0002, 3);
        checks++;
        if (opcode !== 6'h0C || mode !== 2'd2) begin failures++; $display("FAIL decode opcode=%h mode=%0d exp 0c 2", opcode, mode); end
    endtask

    task test_stage_walk();
        go(3'd2, 2'd0);
        go(3'd3, 2'd0);
        go(3'd4, 2'd0);
        go(3'd0, 2'd0);
        checks++;
        if (pc !== 32'h1) begin failures++; $display("FAIL walk_pc got=%h exp=1", pc); end
        fetch($urandom, 0);
    endtask

    task test_pc_src();
        jump_target = 32'h20;
        go(3'd0, 2'd1);
        fetch($urandom, 1);
        br_offset = 16'hFFF0;
        go(3'd0, 2'd2);
        checks++;
        if (pc !== 32'h10) begin failures++; $display("FAIL branch_pc got=%h exp=10", pc); end
        fetch($urandom, 2);
        jump_target = 32'h400;
        go(3'd0, 2'd1);
        checks++;
        if (pc !== 32'h400) begin failures++; $display("FAIL jump_pc got=%h exp=400", pc); end
        fetch($urandom, 0);
        ret_addr = 32'h55;
        go(3'd0, 2'd3);
        checks++;
        if (pc !== 32'h55) begin failures++; $display("FAIL ret_pc got=%h exp=55", pc); end
        fetch($urandom, 1);
    endtask

    task test_idle_ack();
        imem_ack = 1;
        imem_data = ~exp_ir;
        go(3'd2, 2'd0);
        go(3'd3, 2'd0);
        imem_ack = 0;
        checks++;
        if (ir !== exp_ir || instr_count !== exp_cnt) begin failures++; $display("FAIL idle_ack ir=%h cnt=%0d exp ir=%h cnt=%0d", ir, instr_count, exp_ir, exp_cnt); end
        go(3'd0, 2'd0);
    endtask

    task test_timeout();
        int t, n;
        t = 0;
        n = 0;
        while (!imem_req && t < 20) begin tick(); t++; end
        while (imem_req && n < 40) begin tick(); n++; end
        checks++;
        if (n !== 15 || fetch_err !== 1 || state !== 0) begin failures++; $display("FAIL timeout req_cycles=%0d err=%b st=%0d exp 15 1 0", n, fetch_err, state); end
        imem_ack = 1;
        imem_data = ~exp_ir;
        tick();
        tick();
        imem_ack = 0;
        tick();
        checks++;
        if (ir !== exp_ir || instr_count !== exp_cnt || imem_req !== 0 || state !== 0 || pc !== exp_pc || fetch_err !== 1)
            begin failures++; $display("FAIL halt_hold ir=%h cnt=%0d req=%b st=%0d pc=%h err=%b", ir, instr_count, imem_req, state, pc, fetch_err); end
        reset = 1;
        tick();
        reset = 0;
        checks++;
        if (fetch_err !== 0 || pc !== 0) begin failures++; $display("FAIL err_clear err=%b pc=%h exp 0 0", fetch_err, pc); end
        exp_pc = 0; exp_ir = 0; exp_cnt = 0;
    endtask

    task test_reset_mid_fetch();
        int t;
        fetch(32'hDEAD_BEEF, 1);
        go(3'd0, 2'd0);
        t = 0;
        while (!imem_req && t < 20) begin tick(); t++; end
        tick();
        reset = 1;
        tick();
        checks++;
        if (imem_req !== 0 || ir !== 0 || instr_count !== 0 || state !== 0 || pc !== 0)
            begin failures++; $display("FAIL mid_reset req=%b ir=%h cnt=%0d st=%0d pc=%h", imem_req, ir, instr_count, state, pc); end
        exp_pc = 0; exp_ir = 0; exp_cnt = 0;
        reset = 0;
        imem_ack = 1;
        imem_data = 32'h1234_5678;
        tick();
        imem_ack = 0;
        checks++;
        if (ir !== 0 || instr_count !== 0 || imem_req !== 1) begin failures++; $display("FAIL late_ack ir=%h cnt=%0d req=%b exp 0 0 1", ir, instr_count, imem_req); end
        fetch($urandom, 0);
    endtask

    task test_count_wrap();
        go(3'd0, 2'd0);
        force dut.instr_count = 16'hFFFF;
        #1;
        release dut.instr_count;
        exp_cnt = 16'hFFFF;
        fetch($urandom, 1);
        checks++;
        if (instr_count !== 16'h0) begin failures++; $display("FAIL count_wrap got=%h exp=0", instr_count); end
    endtask

    task test_random();
        logic [2:0] ns;
        for (int i = 0; i < 40; i++) begin
            for (int s = 0; s < 6; s++) begin
                ns = s == 5 ? 3'd0 : 3'($urandom_range(0, 7));
                jump_target = $urandom;
                ret_addr = $urandom;
                br_offset = 16'($urandom);
                go(ns, 2'($urandom_range(0, 3)));
                if (ns == 0 || ns > 3'd4) break;
            end
            fetch($urandom, $urandom_range(0, 4));
        end
    endtask

    initial begin
        test_reset();
        test_fetch_latency();
        test_stage_walk();
        test_pc_src();
        test_idle_ack();
        test_timeout();
        test_reset_mid_fetch();
        test_count_wrap();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
